// File: rtl/layer_tdm.sv
// Time-multiplexed fully-connected layer: LANES shared MAC units sweep all neurons
// over a buffered input vector and stream results out with their neuron index.
module layer_tdm #(
    parameter int    NEURONS_NUM          = 10,
    parameter int    INPUTS_NUM           = 30,
    parameter int    DATA_WIDTH           = 16,
    parameter int    WEIGHT_INTEGER_WIDTH = 4,
    parameter int    LANES                = 2,
    parameter int    LAYER_ID             = 3,
    parameter string ACT_TYPE             = "relu"
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_weight_valid,
    input  logic                           i_bias_valid,
    input  logic [31:0]                    i_weight_value,
    input  logic [31:0]                    i_bias_value,
    input  logic [31:0]                    i_layer_id,
    input  logic [31:0]                    i_neuron_id,
    input  logic                           i_data_in_valid,
    input  logic [DATA_WIDTH-1:0]          i_data_in,
    output logic                           o_in_ready,
    output logic                           o_data_out_valid,
    output logic [DATA_WIDTH-1:0]          o_data_out,
    output logic [$clog2(NEURONS_NUM)-1:0] o_neuron_idx,
    input  logic                           i_data_out_ready,
    output logic                           o_busy
);

    localparam int FRAC    = DATA_WIDTH - WEIGHT_INTEGER_WIDTH;
    localparam int IDX_W   = $clog2(NEURONS_NUM);
    localparam int GROUPS  = NEURONS_NUM / LANES;
    localparam int G_W     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int L_W     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int X_W     = (INPUTS_NUM > 1) ? $clog2(INPUTS_NUM) : 1;
    localparam int K_W     = $clog2(INPUTS_NUM + 2);
    localparam int PROD_W  = 2 * DATA_WIDTH;
    localparam int ACC_W   = 2 * DATA_WIDTH + $clog2(INPUTS_NUM) + 1;
    localparam int SUM_W   = ACC_W + 1;
    localparam bit IS_RELU = (ACT_TYPE == "relu");

    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {LOAD, COMPUTE, ACT, DRAIN} state_t;

    state_t state, state_next;

    logic [X_W-1:0] cnt;
    logic [K_W-1:0] k;
    logic [G_W-1:0] g;
    logic [L_W-1:0] lane;
    logic           rd_valid, mul_valid;

    logic [DATA_WIDTH-1:0] x_mem [INPUTS_NUM];
    logic [DATA_WIDTH-1:0] w_mem [NEURONS_NUM][INPUTS_NUM];
    logic [DATA_WIDTH-1:0] bias  [NEURONS_NUM];
    logic [X_W-1:0]        wptr  [NEURONS_NUM];

    logic signed [DATA_WIDTH-1:0] x_q;
    logic signed [DATA_WIDTH-1:0] w_q      [LANES];
    logic signed [PROD_W-1:0]     prod     [LANES];
    logic signed [ACC_W-1:0]      acc      [LANES];
    logic signed [SUM_W-1:0]      sum      [LANES];
    logic signed [SUM_W-1:0]      shr      [LANES];
    logic [DATA_WIDTH-1:0]        res      [LANES];
    logic [DATA_WIDTH-1:0]        res_next [LANES];

    function automatic logic [IDX_W-1:0] neuron_of(input logic [G_W-1:0] gi, input int l);
        return IDX_W'(int'(gi) * LANES + l);
    endfunction

    logic             in_fire, out_fire, last_sample, last_lane, last_group, compute_done;
    logic             w_match, b_match;
    logic [IDX_W-1:0] cfg_n;
    logic [X_W-1:0]   k_rd;

    assign in_fire      = (state == LOAD) && i_data_in_valid;
    assign out_fire     = (state == DRAIN) && i_data_out_ready;
    assign last_sample  = (cnt == X_W'(INPUTS_NUM - 1));
    assign last_lane    = (lane == L_W'(LANES - 1));
    assign last_group   = (g == G_W'(GROUPS - 1));
    assign compute_done = (k == K_W'(INPUTS_NUM + 1));
    assign k_rd         = X_W'(k);

    assign w_match = i_weight_valid && !o_busy && (i_layer_id == 32'(LAYER_ID))
                     && (i_neuron_id < 32'(NEURONS_NUM));
    assign b_match = i_bias_valid && !o_busy && (i_layer_id == 32'(LAYER_ID))
                     && (i_neuron_id < 32'(NEURONS_NUM));
    assign cfg_n   = i_neuron_id[IDX_W-1:0];

    logic unused_cfg_bits;
    assign unused_cfg_bits = &{1'b0, i_weight_value[31:DATA_WIDTH], i_bias_value[31:DATA_WIDTH]};

    // NOTE: every output of a combinational block gets a default before any branch,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            LOAD:    if (in_fire && last_sample) state_next = COMPUTE;
            COMPUTE: if (compute_done) state_next = ACT;
            ACT:     state_next = DRAIN;
            DRAIN:   if (out_fire && last_lane) state_next = last_group ? LOAD : COMPUTE;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LOAD;
            cnt       <= '0;
            k         <= '0;
            g         <= '0;
            lane      <= '0;
            rd_valid  <= 1'b0;
            mul_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (in_fire) cnt <= last_sample ? '0 : cnt + X_W'(1);
            k         <= (state == COMPUTE) ? k + K_W'(1) : '0;
            rd_valid  <= (state == COMPUTE) && (k < K_W'(INPUTS_NUM));
            mul_valid <= rd_valid;
            if (out_fire) begin
                lane <= last_lane ? '0 : lane + L_W'(1);
                if (last_lane) g <= last_group ? '0 : g + G_W'(1);
            end
        end
    end

    // NOTE: the sample buffer, weight RAM and MAC pipeline registers carry no reset;
    // their contents are only consumed behind the control valids, and a resettable
    // RAM would not map onto block memory.
    always_ff @(posedge clk) begin
        if (in_fire) x_mem[cnt] <= i_data_in;
        if (w_match) w_mem[cfg_n][wptr[cfg_n]] <= i_weight_value[DATA_WIDTH-1:0];
        x_q <= x_mem[k_rd];
        for (int l = 0; l < LANES; l++) begin
            w_q[l]  <= w_mem[neuron_of(g, l)][k_rd];
            prod[l] <= PROD_W'(x_q) * PROD_W'(w_q[l]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < NEURONS_NUM; n++) begin
                bias[n] <= '0;
                wptr[n] <= '0;
            end
        end else begin
            if (w_match) wptr[cfg_n] <= (wptr[cfg_n] == X_W'(INPUTS_NUM - 1)) ? '0 : wptr[cfg_n] + X_W'(1);
            if (b_match) bias[cfg_n] <= i_bias_value[DATA_WIDTH-1:0];
        end
    end

    // Bias is lifted into the accumulator's fixed-point scale before rounding back down.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            sum[l] = SUM_W'(acc[l]) + (SUM_W'($signed(bias[neuron_of(g, l)])) <<< FRAC);
            shr[l] = sum[l] >>> FRAC;
            res_next[l] = shr[l][DATA_WIDTH-1:0];
            if (shr[l] > SAT_MAX) res_next[l] = SAT_MAX[DATA_WIDTH-1:0];
            if (shr[l] < SAT_MIN) res_next[l] = SAT_MIN[DATA_WIDTH-1:0];
            if (IS_RELU && shr[l][SUM_W-1]) res_next[l] = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int l = 0; l < LANES; l++) begin
                acc[l] <= '0;
                res[l] <= '0;
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (state == COMPUTE && k == '0) acc[l] <= '0;
                else if (mul_valid)              acc[l] <= acc[l] + ACC_W'(prod[l]);
                if (state == ACT) res[l] <= res_next[l];
            end
        end
    end

    assign o_in_ready       = (state == LOAD);
    assign o_busy           = (state != LOAD);
    assign o_data_out_valid = (state == DRAIN);
    assign o_data_out       = res[lane];
    assign o_neuron_idx     = neuron_of(g, int'(lane));

endmodule

// File: tb/tb_layer_tdm.sv
// Bench for layer_tdm: relu and linear instances share stimulus; results are
// compared against hand-computed vectors and a dot-product reference model.
module tb_layer_tdm;

    localparam int NN   = 10;
    localparam int NI   = 30;
    localparam int FRAC = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        weight_valid = 1'b0, bias_valid = 1'b0;
    logic [31:0] weight_value = '0, bias_value = '0, layer_id = '0, neuron_id = '0;
    logic        data_in_valid = 1'b0;
    logic [15:0] data_in = '0;
    logic        out_ready = 1'b1;

    logic        r_in_ready, r_valid, r_busy, l_in_ready, l_valid, l_busy;
    logic [15:0] r_data, l_data;
    logic [3:0]  r_idx, l_idx;

    always #5 clk = ~clk;

    layer_tdm #(.ACT_TYPE("relu")) dut_relu (
        .clk(clk), .reset(reset),
        .i_weight_valid(weight_valid), .i_bias_valid(bias_valid),
        .i_weight_value(weight_value), .i_bias_value(bias_value),
        .i_layer_id(layer_id), .i_neuron_id(neuron_id),
        .i_data_in_valid(data_in_valid), .i_data_in(data_in),
        .o_in_ready(r_in_ready), .o_data_out_valid(r_valid), .o_data_out(r_data),
        .o_neuron_idx(r_idx), .i_data_out_ready(out_ready), .o_busy(r_busy)
    );

    layer_tdm #(.ACT_TYPE("linear")) dut_lin (
        .clk(clk), .reset(reset),
        .i_weight_valid(weight_valid), .i_bias_valid(bias_valid),
        .i_weight_value(weight_value), .i_bias_value(bias_value),
        .i_layer_id(layer_id), .i_neuron_id(neuron_id),
        .i_data_in_valid(data_in_valid), .i_data_in(data_in),
        .o_in_ready(l_in_ready), .o_data_out_valid(l_valid), .o_data_out(l_data),
        .o_neuron_idx(l_idx), .i_data_out_ready(out_ready), .o_busy(l_busy)
    );

    // Reference state: what the configuration bus has written so far.
    logic [15:0] wm [NN][NI];
    logic [15:0] bm [NN];
    int          mptr [NN];
    logic [15:0] xv [NI];
    logic [15:0] exp_r [NN];
    logic [15:0] exp_l [NN];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] w;
        logic [15:0] b3;
        logic [15:0] x;
        logic [15:0] e_other_r;
        logic [15:0] e_other_l;
        logic [15:0] e3_r;
        logic [15:0] e3_l;
    } vec_t;

    vec_t tbl [4];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    function automatic logic [15:0] ref_out(input int n, input bit relu);
        longint s = 0;
        for (int i = 0; i < NI; i++)
            s += longint'($signed(wm[n][i])) * longint'($signed(xv[i]));
        s += longint'($signed(bm[n])) * (longint'(1) << FRAC);
        s = s >>> FRAC;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return 16'(s);
    endfunction

    task automatic fill_exp_from_model();
        for (int n = 0; n < NN; n++) begin
            exp_r[n] = ref_out(n, 1'b1);
            exp_l[n] = ref_out(n, 1'b0);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < NN; n++) begin
            mptr[n] = 0;
            bm[n]   = '0;
        end
    endtask

    task automatic cfg(input bit wv, input bit bv, input logic [15:0] wval,
                       input logic [15:0] bval, input int layer, input int neuron);
        @(negedge clk);
        weight_valid = wv;
        bias_valid   = bv;
        weight_value = {16'($urandom), wval};
        bias_value   = {16'($urandom), bval};
        layer_id     = layer;
        neuron_id    = neuron;
        if (layer == 3 && neuron >= 0 && neuron < NN) begin
            if (wv) begin
                wm[neuron][mptr[neuron]] = wval;
                mptr[neuron] = (mptr[neuron] + 1) % NI;
            end
            if (bv) bm[neuron] = bval;
        end
        @(posedge clk);
        #1;
        weight_valid = 1'b0;
        bias_valid   = 1'b0;
    endtask

    function automatic logic [15:0] rand_val(input int mode);
        if (mode == 2) return 16'($urandom);
        return 16'($urandom_range(0, 16'h3FFF)) - 16'h2000;
    endfunction

    task automatic load_weights(input int mode, input logic [15:0] val);
        for (int n = 0; n < NN; n++)
            for (int i = 0; i < NI; i++)
                cfg(1'b1, 1'b0, (mode == 0) ? val : rand_val(mode), 16'h0, 3, n);
    endtask

    task automatic drive_vec(input bit gaps);
        for (int i = 0; i < NI; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    data_in_valid = 1'b0;
                end
            end
            @(negedge clk);
            data_in_valid = 1'b1;
            data_in       = xv[i];
        end
    endtask

    // mode 0: ready high; 1: random ready; 2: ready low for 5 cycles once neuron 2 is shown.
    task automatic collect(input int mode, input bit junk);
        int c = 0, nr = 0, nl = 0, last_hs = 0, drop = 0;
        bit prev_v = 1'b0, rdy;
        while (nr < NN && c < 4000) begin
            @(negedge clk);
            c++;
            case (mode)
                1: rdy = ($urandom_range(0, 3) != 0);
                2: begin
                    rdy = !(nr == 2 && r_valid && drop < 5);
                    if (!rdy) drop++;
                end
                default: rdy = 1'b1;
            endcase
            out_ready     = rdy;
            data_in_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            data_in       = 16'($urandom);
            if (junk) begin
                weight_valid = 1'($urandom_range(0, 1));
                bias_valid   = 1'($urandom_range(0, 1));
                layer_id     = 3;
                neuron_id    = $urandom_range(0, NN - 1);
                weight_value = $urandom;
                bias_value   = $urandom;
            end
            if (r_valid) begin
                if (!prev_v) begin
                    if (nr == 0) check("first_latency", c - 1, NI + 3);
                    else         check("group_latency", c - last_hs - 1, NI + 3);
                end
                check("relu_idx", r_idx, nr);
                check("relu_data", r_data, exp_r[nr]);
                check("busy_drain", r_busy, 1);
                if (rdy) begin
                    nr++;
                    last_hs = c;
                end
            end
            if (l_valid && nl < NN) begin
                check("lin_idx", l_idx, nl);
                check("lin_data", l_data, exp_l[nl]);
                if (rdy) nl++;
            end
            prev_v = r_valid;
        end
        check("relu_count", nr, NN);
        check("lin_count", nl, NN);
        @(negedge clk);
        data_in_valid = 1'b0;
        weight_valid  = 1'b0;
        bias_valid    = 1'b0;
        out_ready     = 1'b1;
        check("in_ready_back", r_in_ready, 1);
        check("busy_back", r_busy, 0);
        check("no_extra_out", r_valid, 0);
        check("lin_in_ready_back", l_in_ready, 1);
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", r_in_ready, 1);
        check("rst_valid", r_valid, 0);
        check("rst_data", r_data, 0);
        check("rst_idx", r_idx, 0);
        check("rst_busy", r_busy, 0);
        check("rst_lin_busy", l_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{w: 16'h1000, b3: 16'h0000, x: 16'h0100,
                   e_other_r: 16'h1E00, e_other_l: 16'h1E00, e3_r: 16'h1E00, e3_l: 16'h1E00};
        tbl[1] = '{w: 16'h1000, b3: 16'hF000, x: 16'h0080,
                   e_other_r: 16'h0F00, e_other_l: 16'h0F00, e3_r: 16'h0000, e3_l: 16'hFF00};
        tbl[2] = '{w: 16'h7FFF, b3: 16'h0000, x: 16'h7FFF,
                   e_other_r: 16'h7FFF, e_other_l: 16'h7FFF, e3_r: 16'h7FFF, e3_l: 16'h7FFF};
        tbl[3] = '{w: 16'h8000, b3: 16'h0000, x: 16'h7FFF,
                   e_other_r: 16'h0000, e_other_l: 16'h8000, e3_r: 16'h0000, e3_l: 16'h8000};

        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        reset = 1'b0;

        // Hand-computed vectors: nominal, bias/relu, positive and negative saturation.
        for (int i = 0; i < 4; i++) begin
            load_weights(0, tbl[i].w);
            for (int n = 0; n < NN; n++)
                cfg(1'b0, 1'b1, 16'h0, (n == 3) ? tbl[i].b3 : 16'h0000, 3, n);
            for (int j = 0; j < NI; j++) xv[j] = tbl[i].x;
            for (int n = 0; n < NN; n++) begin
                exp_r[n] = (n == 3) ? tbl[i].e3_r : tbl[i].e_other_r;
                exp_l[n] = (n == 3) ? tbl[i].e3_l : tbl[i].e_other_l;
            end
            drive_vec(1'b0);
            collect(0, 1'b0);
        end

        // Reset in the middle of COMPUTE, then a clean rerun of the nominal vector.
        load_weights(0, 16'h1000);
        for (int n = 0; n < NN; n++) cfg(1'b0, 1'b1, 16'h0, 16'h0, 3, n);
        for (int j = 0; j < NI; j++) xv[j] = 16'h0100;
        drive_vec(1'b0);
        @(negedge clk);
        data_in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("busy_before_reset", r_busy, 1);
        reset = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        fill_exp_from_model();
        drive_vec(1'b0);
        collect(0, 1'b0);

        // Backpressure with junk inputs and config writes while busy.
        drive_vec(1'b1);
        collect(2, 1'b1);

        // Address filter, pointer wrap and simultaneous weight+bias write.
        cfg(1'b1, 1'b0, 16'h7FFF, 16'h0, 2, 0);
        cfg(1'b1, 1'b0, 16'h7FFF, 16'h0, 3, 10);
        cfg(1'b0, 1'b1, 16'h0, 16'h7000, 2, 1);
        cfg(1'b0, 1'b1, 16'h0, 16'h7000, 3, 10);
        for (int j = 0; j < 31; j++) cfg(1'b1, 1'b0, (j == 30) ? 16'h2000 : 16'h1000, 16'h0, 3, 0);
        cfg(1'b1, 1'b1, 16'h3000, 16'h0100, 3, 5);
        fill_exp_from_model();
        check("model_wrap_n0", exp_r[0], 16'h1F00);
        drive_vec(1'b0);
        collect(0, 1'b0);

        // Randomized vectors against the reference model.
        for (int it = 0; it < 4; it++) begin
            int m;
            m = (it % 2 == 0) ? 1 : 2;
            load_weights(m, 16'h0);
            for (int n = 0; n < NN; n++) cfg(1'b0, 1'b1, 16'h0, rand_val(m), 3, n);
            for (int j = 0; j < NI; j++) xv[j] = rand_val(m);
            fill_exp_from_model();
            drive_vec(1'b1);
            collect(1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_tdm.md
# layer_tdm

Time-multiplexed, fully parametrised fully-connected layer. It replaces one hard-instantiated neuron per output with `LANES` shared multiply-accumulate units that iterate over all `NEURONS_NUM` neurons. An input vector of `INPUTS_NUM` samples is buffered, and the results are emitted as a serial valid/ready stream tagged with the neuron index. Weights and biases use the existing runtime configuration bus (layer id / neuron id), so the block drops into the network between the input serializer and the next layer.

## Interface
Parameters
- `NEURONS_NUM`, 10: neurons in layer; must be a multiple of `LANES`.
- `INPUTS_NUM`, 30: samples per input vector.
- `DATA_WIDTH`, 16: signed data/weight/bias width.
- `WEIGHT_INTEGER_WIDTH`, 4: integer bits incl. sign. FRAC = `DATA_WIDTH - WEIGHT_INTEGER_WIDTH`; data, weights and biases all use this format.
- `LANES`, 2: neurons computed in parallel.
- `LAYER_ID`, 3: config bus address of this layer.
- `ACT_TYPE`, "relu": "relu" or "linear".

Ports
- `clk`, in, 1: clock; one clock, all logic on rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `i_weight_valid`, in, 1: weight write strobe.
- `i_bias_valid`, in, 1: bias write strobe.
- `i_weight_value`, in, 32: weight in `[DATA_WIDTH-1:0]`.
- `i_bias_value`, in, 32: bias in `[DATA_WIDTH-1:0]`.
- `i_layer_id`, in, 32: target layer of the write.
- `i_neuron_id`, in, 32: target neuron of the write.
- `i_data_in_valid`, in, 1: input sample strobe.
- `i_data_in`, in, `DATA_WIDTH`: input sample.
- `o_in_ready`, out, 1: block is accepting input samples.
- `o_data_out_valid`, out, 1: result valid.
- `o_data_out`, out, `DATA_WIDTH`: result.
- `o_neuron_idx`, out, `$clog2(NEURONS_NUM)`: neuron index of `o_data_out`.
- `i_data_out_ready`, in, 1: downstream accepts the result.
- `o_busy`, out, 1: high in COMPUTE, ACT and DRAIN.

## Operation
- **Config address match.** A write matches when its strobe is high, `i_layer_id == LAYER_ID` and `i_neuron_id < NEURONS_NUM`. Non-matching writes are ignored.
- **Weight writes.** Each neuron has a write pointer. A matching weight write stores to `w[n][ptr[n]]`, then the pointer increments and wraps from `INPUTS_NUM-1` to 0.
- **Bias writes.** A matching bias write overwrites `b[n]`.
- **Simultaneous config writes.** A weight write and a bias write in the same cycle both take effect.
- **Config writes while busy.** Writes while `o_busy = 1` are dropped.
- **Reset of config state.** Reset clears the write pointers and biases (to 0). Weight RAM contents are not reset.
- **LOAD state.** `o_in_ready = 1`. Each `i_data_in_valid` stores a sample to `x[cnt]`, then `cnt` increments. Accepting sample `INPUTS_NUM-1` moves the state to COMPUTE with group g = 0.
- **Input while not ready.** `i_data_in_valid` while `o_in_ready = 0` is dropped.
- **COMPUTE state.** For lane l in 0..LANES-1, neuron n = g·LANES + l accumulates `x[k]·w[n][k]` for k = 0..INPUTS_NUM-1, one k per cycle per lane. Weight read and multiply are each registered, so COMPUTE lasts `INPUTS_NUM+2` cycles.
- **Accumulator.** Signed, width `2·DATA_WIDTH + $clog2(INPUTS_NUM) + 1`, cleared on entry to COMPUTE.
- **ACT state** (1 cycle), per lane:
  - sum = acc + (b[n] <<< FRAC);
  - r = sum >>> FRAC (arithmetic shift, truncate);
  - saturate r to [−2^(DW−1), 2^(DW−1)−1];
  - if "relu" and r < 0, r = 0.
- **DRAIN state.** Lane results are emitted in lane order, one per handshake (`o_data_out_valid && i_data_out_ready`).
  - After the last lane, if g < NEURONS_NUM/LANES − 1 the state moves to COMPUTE with g+1; otherwise to LOAD with `cnt = 0`.
- **Output order.** Neuron 0..NEURONS_NUM−1, strictly ascending.
- **Reset mid-operation.** The state returns to LOAD. Partial input, accumulators and pending outputs are discarded.

## Timing
- **Reset values:** `o_in_ready = 1`, `o_data_out_valid = 0`, `o_data_out = 0`, `o_neuron_idx = 0`, `o_busy = 0`.
- **Last input to first output.** `o_data_out_valid` first rises exactly `INPUTS_NUM+3` rising edges after the edge that accepted the last input sample.
- **Output hold.** While `o_data_out_valid && !i_data_out_ready`, `o_data_out` and `o_neuron_idx` hold stable.
- **Back-to-back outputs.** With ready held high, results of one group leave on consecutive cycles.
- **Between groups.** The next group's first output follows `INPUTS_NUM+3` cycles after the last handshake of the previous group.
- **Return to LOAD.** `o_in_ready` rises the cycle after the final output handshake. `o_busy` falls on the same edge.
- **Full-vector throughput** (ready always high): INPUTS_NUM + (NEURONS_NUM/LANES)·(INPUTS_NUM+3+LANES) cycles.

## Test plan
1. **Nominal result.** Defaults (FRAC = 12). All weights 0x1000, biases 0, 30 inputs of 0x0100 → neurons 0..9 each output 0x1E00, idx 0..9 in order.
2. **Bias and ReLU.** Weights 0x1000, `b[3] = 0xF000` (−1.0), inputs 0x0080. Neuron 3 → 0x0000 under relu; neuron 3 → 0xFF00 under "linear"; others → 0x0F00.
3. **Saturation, "linear".** Inputs 0x7FFF with all weights 0x7FFF → 0x7FFF. Same inputs with all weights 0x8000 → 0x8000; with relu → 0x0000.
4. **Backpressure.** Drop `i_data_out_ready` for 5 cycles after the 2nd handshake → data/idx stable, no loss, no duplicates. Inputs driven during DRAIN are dropped.
5. **Config filter and wrap.** Writes with `i_layer_id = 2`, or `i_neuron_id = 10`, leave results unchanged. 31 weight writes to neuron 0 overwrite `w[0][0]` with the 31st value.
6. **Reset mid-operation.** Assert `reset` mid-COMPUTE → outputs at reset values immediately, `o_in_ready = 1`. A fresh vector then reproduces scenario 1, with the first-output latency of exactly 33 edges.
